// File: rtl/div_issue_ctrl.sv
// EX-stage issue control for DIV/DIVU: launches the multi-cycle divider, stalls the
// pipeline until the result returns, and handles flush and watchdog abort.
module div_issue_ctrl #(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_div_i,
    input  logic        is_divu_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        timeout_o,
    output logic [31:0] div_count_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WD_W   = 6;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic              req_c;
    logic              capture_c;
    logic              wd_expire_c;
    logic [WD_W-1:0]   wd_cnt_q;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] op2_q;
    logic              signed_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] count_q;
    logic              timeout_q;

    // Flush outranks ready; the watchdog only fires when neither is present.
    assign req_c       = (is_div_i | is_divu_i) & ~flush_i;
    assign capture_c   = (state_q == BUSY) & div_ready_i & ~flush_i;
    assign wd_expire_c = (state_q == BUSY) & ~div_ready_i & ~flush_i & (wd_cnt_q == WD_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_c) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (flush_i || wd_expire_c) begin
                    state_d = IDLE;
                end else if (div_ready_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!stall_i || flush_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode; the stall is dropped on watchdog abort so the instruction can leave EX
    always_comb begin
        div_start_o = 1'b0;
        div_annul_o = 1'b0;
        stallreq_o  = 1'b0;
        whilo_o     = 1'b0;
        case (state_q)
            IDLE: begin
                stallreq_o = req_c;
            end
            BUSY: begin
                stallreq_o = ~wd_expire_c;
                if (flush_i || wd_expire_c) begin
                    div_annul_o = 1'b1;
                end else begin
                    div_start_o = 1'b1;
                end
            end
            DONE: begin
                whilo_o = ~flush_i;
            end
            default: ;
        endcase
    end

    // Operand latch, watchdog, result capture and completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            op1_q     <= '0;
            op2_q     <= '0;
            signed_q  <= 1'b0;
            wd_cnt_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_expire_c;
            if (state_q == IDLE && req_c) begin
                op1_q    <= reg1_i;
                op2_q    <= reg2_i;
                signed_q <= is_div_i;
                wd_cnt_q <= '0;
            end
            if (state_q == BUSY) begin
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
            if (capture_c) begin
                hi_q    <= div_result_i[63:32];
                lo_q    <= div_result_i[31:0];
                count_q <= count_q + DATA_W'(1);
            end
        end
    end

    assign div_signed_o  = signed_q;
    assign div_opdata1_o = op1_q;
    assign div_opdata2_o = op2_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign div_count_o   = count_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider stub and a HI/LO scoreboard.
module tb_div_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        is_div;
    logic        is_divu;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic        flush;
    logic        stall_in;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_opdata1_o;
    logic [31:0] div_opdata2_o;
    logic [63:0] div_result;
    logic        div_ready;
    logic        stallreq_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        timeout_o;
    logic [31:0] div_count_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    div_issue_ctrl #(.TIMEOUT(40)) dut (
        .clk           (clk),
        .rst           (rst),
        .is_div_i      (is_div),
        .is_divu_i     (is_divu),
        .reg1_i        (reg1),
        .reg2_i        (reg2),
        .flush_i       (flush),
        .stall_i       (stall_in),
        .div_start_o   (div_start_o),
        .div_annul_o   (div_annul_o),
        .div_signed_o  (div_signed_o),
        .div_opdata1_o (div_opdata1_o),
        .div_opdata2_o (div_opdata2_o),
        .div_result_i  (div_result),
        .div_ready_i   (div_ready),
        .stallreq_o    (stallreq_o),
        .whilo_o       (whilo_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .timeout_o     (timeout_o),
        .div_count_o   (div_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider stub: ready after 36 start cycles (4 for a zero divisor)
    logic [5:0]         dv_cnt;
    logic               stub_en;
    logic signed [31:0] sq;
    logic signed [31:0] sr;

    always @(posedge clk) begin
        if (rst || !div_start_o) dv_cnt <= 6'd0;
        else                     dv_cnt <= dv_cnt + 6'd1;
    end

    assign div_ready = stub_en && (dv_cnt == ((div_opdata2_o == 32'd0) ? 6'd3 : 6'd35));

    always_comb begin
        sq = '0;
        sr = '0;
        div_result = '0;
        if (div_opdata2_o != 32'd0) begin
            if (div_signed_o) begin
                sq = $signed(div_opdata1_o) / $signed(div_opdata2_o);
                sr = $signed(div_opdata1_o) % $signed(div_opdata2_o);
                div_result = {sr, sq};
            end else begin
                div_result = {div_opdata1_o % div_opdata2_o, div_opdata1_o / div_opdata2_o};
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every writeback cycle consumes one expected {hi,lo}
    always @(negedge clk) begin
        if (!rst && whilo_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected actual=%0h required=none", {hi_o, lo_o});
            end else begin
                chk("wb_hilo", {hi_o, lo_o}, exp_q.pop_front());
            end
        end
    end

    task automatic do_div(input logic dv, input logic du, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int elat,
                          input int nstall, input logic [31:0] ecnt);
        int n;
        logic stall_ok;
        logic start_ok;
        is_div   = dv;
        is_divu  = du;
        reg1     = a;
        reg2     = b;
        stall_in = (nstall > 0);
        for (int k = 0; k <= nstall; k++) exp_q.push_back({ehi, elo});
        @(negedge clk);
        chk("req_stallreq", 64'(stallreq_o), 64'd1);
        chk("req_start", 64'(div_start_o), 64'd0);
        chk("req_whilo", 64'(whilo_o), 64'd0);
        n = 0;
        stall_ok = 1'b1;
        start_ok = 1'b1;
        while (!whilo_o && n < 100) begin
            @(posedge clk); #1;
            n++;
            @(negedge clk);
            if (n == 1) begin
                chk("busy_op1", 64'(div_opdata1_o), 64'(a));
                chk("busy_op2", 64'(div_opdata2_o), 64'(b));
                chk("busy_signed", 64'(div_signed_o), 64'(dv));
            end
            if (!whilo_o) begin
                if (!stallreq_o)  stall_ok = 1'b0;
                if (!div_start_o) start_ok = 1'b0;
            end
        end
        chk("done_latency", 64'(n), 64'(elat));
        chk("busy_stall_held", 64'(stall_ok), 64'd1);
        chk("busy_start_held", 64'(start_ok), 64'd1);
        chk("done_stallreq", 64'(stallreq_o), 64'd0);
        chk("done_start", 64'(div_start_o), 64'd0);
        chk("done_count", 64'(div_count_o), 64'(ecnt));
        for (int k = 1; k <= nstall; k++) begin
            @(posedge clk); #1;
            if (k == nstall) stall_in = 1'b0;
            @(negedge clk);
            chk("hold_whilo", 64'(whilo_o), 64'd1);
            chk("hold_start", 64'(div_start_o), 64'd0);
            chk("hold_count", 64'(div_count_o), 64'(ecnt));
        end
        @(posedge clk); #1;
        is_div   = 1'b0;
        is_divu  = 1'b0;
        stall_in = 1'b0;
    endtask

    task automatic do_flush(input logic dv, input logic du, input logic [31:0] a, input logic [31:0] b,
                            input int flush_at, input logic [31:0] ecnt);
        is_div  = dv;
        is_divu = du;
        reg1    = a;
        reg2    = b;
        @(negedge clk);
        chk("fl_req_stallreq", 64'(stallreq_o), 64'd1);
        for (int k = 1; k < flush_at; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("fl_annul", 64'(div_annul_o), 64'd1);
        chk("fl_start", 64'(div_start_o), 64'd0);
        chk("fl_whilo", 64'(whilo_o), 64'd0);
        @(posedge clk); #1;
        flush   = 1'b0;
        is_div  = 1'b0;
        is_divu = 1'b0;
        @(negedge clk);
        chk("fl_idle_annul", 64'(div_annul_o), 64'd0);
        chk("fl_idle_start", 64'(div_start_o), 64'd0);
        chk("fl_idle_stallreq", 64'(stallreq_o), 64'd0);
        chk("fl_idle_whilo", 64'(whilo_o), 64'd0);
        chk("fl_count", 64'(div_count_o), 64'(ecnt));
        @(posedge clk); #1;
    endtask

    task automatic do_timeout(input logic [31:0] ecnt);
        int n;
        stub_en = 1'b0;
        is_divu = 1'b1;
        reg1    = 32'd1;
        reg2    = 32'd1;
        @(negedge clk);
        n = 0;
        while (!div_annul_o && n < 100) begin
            @(posedge clk); #1;
            n++;
            @(negedge clk);
        end
        chk("to_busy_cycles", 64'(n), 64'd40);
        chk("to_start", 64'(div_start_o), 64'd0);
        chk("to_stallreq", 64'(stallreq_o), 64'd0);
        chk("to_pulse_early", 64'(timeout_o), 64'd0);
        @(posedge clk); #1;
        is_divu = 1'b0;
        @(negedge clk);
        chk("to_pulse", 64'(timeout_o), 64'd1);
        chk("to_idle_stallreq", 64'(stallreq_o), 64'd0);
        chk("to_idle_annul", 64'(div_annul_o), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_pulse_end", 64'(timeout_o), 64'd0);
        chk("to_count", 64'(div_count_o), 64'(ecnt));
        @(posedge clk); #1;
        stub_en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=hung required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst      = 1'b1;
        is_div   = 1'b0;
        is_divu  = 1'b0;
        reg1     = '0;
        reg2     = '0;
        flush    = 1'b0;
        stall_in = 1'b0;
        stub_en  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_start", 64'(div_start_o), 64'd0);
        chk("rst_annul", 64'(div_annul_o), 64'd0);
        chk("rst_stallreq", 64'(stallreq_o), 64'd0);
        chk("rst_whilo", 64'(whilo_o), 64'd0);
        chk("rst_timeout", 64'(timeout_o), 64'd0);
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        chk("rst_ops", {div_opdata1_o, div_opdata2_o}, 64'd0);
        chk("rst_count", 64'(div_count_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // DIVU 7/2, then back-to-back DIV -7/2
        do_div(1'b0, 1'b1, 32'd7, 32'd2, 32'h1, 32'h3, 37, 0, 32'd1);
        do_div(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 37, 0, 32'd2);
        // Divide by zero
        do_div(1'b1, 1'b0, 32'd5, 32'd0, 32'h0, 32'h0, 5, 0, 32'd3);
        // Writeback held by three stall cycles
        do_div(1'b0, 1'b1, 32'd100, 32'd7, 32'h2, 32'hE, 37, 3, 32'd4);
        // Flush at BUSY cycle 10, then a clean DIVU 9/3
        do_flush(1'b0, 1'b1, 32'd50, 32'd5, 10, 32'd4);
        do_div(1'b0, 1'b1, 32'd9, 32'd3, 32'h0, 32'h3, 37, 0, 32'd5);
        // Flush coinciding with ready (divide by zero readies in BUSY cycle 4)
        do_flush(1'b1, 1'b0, 32'd5, 32'd0, 4, 32'd5);
        // Watchdog abort with the divider stubbed silent
        do_timeout(32'd5);
        // Both decode bits set selects signed: 7 / -2
        do_div(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 37, 0, 32'd6);

        // Reset during BUSY drops start and clears state
        is_divu = 1'b1;
        reg1    = 32'd20;
        reg2    = 32'd4;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rb_start_before", 64'(div_start_o), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        is_divu = 1'b0;
        @(negedge clk);
        chk("rb_start", 64'(div_start_o), 64'd0);
        chk("rb_stallreq", 64'(stallreq_o), 64'd0);
        chk("rb_hilo", {hi_o, lo_o}, 64'd0);
        chk("rb_count", 64'(div_count_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

EX-stage control for the DIV/DIVU path. Accepts a divide request from the EX stage and issues it to the multi-cycle divider (`div`) with its start/annul handshake. Stalls the pipeline until the 64-bit result returns, then presents HI/LO writeback for exactly as long as the instruction remains in EX. Also handles pipeline flush mid-divide and a watchdog timeout.

## Interface
- TIMEOUT, default 40: BUSY cycles without `div_ready_i` before abort.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- is_div_i  in  1  EX holds DIV (signed).
- is_divu_i  in  1  EX holds DIVU (unsigned).
- reg1_i  in  32  dividend (rs).
- reg2_i  in  32  divisor (rt).
- flush_i  in  1  pipeline flush; kills the EX instruction.
- stall_i  in  1  EX held by a later-stage stall; the EX/MEM latch does not accept.
- div_start_o  out  1  divider start; 1 = DivStart, 0 = DivStop.
- div_annul_o  out  1  divider annul.
- div_signed_o  out  1  signed divide select.
- div_opdata1_o  out  32  latched dividend.
- div_opdata2_o  out  32  latched divisor.
- div_result_i  in  64  {remainder, quotient} from divider.
- div_ready_i  in  1  divider result valid.
- stallreq_o  out  1  stall request to pipeline control.
- whilo_o  out  1  HI/LO write enable toward EX/MEM.
- hi_o  out  32  remainder.
- lo_o  out  32  quotient.
- timeout_o  out  1  one-cycle pulse on watchdog abort.
- div_count_o  out  32  completed (non-flushed) divides, wraps.

## Operation
- `req = (is_div_i | is_divu_i) & ~flush_i`. If both decode bits are set, the request is signed.
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE:**
  - `stallreq_o = req` (combinational). `div_start_o = 0`.
  - On `req`: latch `reg1_i`, `reg2_i` and signedness into the operand registers, then go to BUSY.
- **BUSY:**
  - `div_start_o = 1` and `stallreq_o = 1`. Operands stay stable.
  - On `div_ready_i & ~flush_i`: capture `hi_q = div_result_i[63:32]` and `lo_q = div_result_i[31:0]`. Increment `div_count_o`. Go to DONE.
  - On `flush_i` (takes priority over ready): `div_annul_o = 1`, `div_start_o = 0`, go to IDLE. No capture and no count.
  - On watchdog expiry (`wd_cnt == TIMEOUT-1`, no ready): `div_annul_o = 1`, `div_start_o = 0`, pulse `timeout_o` next cycle, go to IDLE. `stallreq_o` is released.
- **DONE:**
  - `div_start_o = 0`; this releases the divider to free.
  - `stallreq_o = 0`. `whilo_o = ~flush_i`. `hi_o = hi_q`, `lo_o = lo_q`.
  - `stall_i = 1`: stay in DONE and do not reissue.
  - `stall_i = 0` or `flush_i = 1`: go to IDLE.
- Outside DONE: `whilo_o = 0`. `hi_o`/`lo_o` hold their last captured value.
- `div_annul_o` is 0 except in the flush and timeout cycles above.
- Signed semantics come from the divider: quotient truncates toward zero, remainder takes the dividend's sign. Divide by zero returns {0,0} with no special flag.
- `wd_cnt` is 6 bits. It clears on entry to BUSY and increments every BUSY cycle.

## Timing
- **Reset:** state IDLE. `div_start_o`, `div_annul_o`, `div_signed_o`, `stallreq_o`, `whilo_o`, `timeout_o` = 0. `div_opdata1_o`, `div_opdata2_o`, `hi_o`, `lo_o`, `div_count_o`, `wd_cnt` = 0.
- A reset during BUSY drops start; the divider is reset by the same `rst`.
- **Normal divide:** request seen in cycle 0 (IDLE, stall asserted). `div_start_o` rises in cycle 1. The divider raises ready in cycle 36. DONE is in cycle 37, with `whilo_o = 1` and stall dropped.
- **Divide by zero:** ready in cycle 4, DONE in cycle 5.
- **Back-to-back divides:** `div_start_o` is 0 for at least one cycle (DONE) between operations, so the divider passes through DivFree. The second request is latched in the IDLE cycle after DONE.
- Flush in the same cycle as `div_ready_i`: the result is discarded.

## Test plan
- DIVU 7 / 2 -> DONE 37 cycles after request: `lo_o = 0x00000003`, `hi_o = 0x00000001`, `whilo_o = 1` for one cycle, `div_count_o = 1`.
- DIV 0xFFFFFFF9 (-7) / 2 -> `lo_o = 0xFFFFFFFD`, `hi_o = 0xFFFFFFFF`. `stallreq_o` high continuously from request cycle until DONE.
- DIV 5 / 0 -> DONE at cycle 5 with `hi_o = lo_o = 0`, `whilo_o = 1`.
- Divide with `stall_i = 1` for 3 cycles in DONE -> `whilo_o` held 4 cycles with the same HI/LO. `div_start_o` stays 0, no second divide, count increments once.
- `flush_i` at cycle 10 of BUSY -> `div_annul_o = 1` that cycle, IDLE next. No `whilo_o`, count unchanged. A following DIVU 9 / 3 completes with `lo_o = 3`, `hi_o = 0`.
- `div_ready_i` held low (stubbed divider), TIMEOUT = 40 -> annul plus a one-cycle `timeout_o` pulse after 40 BUSY cycles, then IDLE with stall released.
